// File: rtl/bram_pkg.sv
// Shared types and constants for the pipelined block-RAM with a ready/valid
// request port and a credit-limited, in-order response FIFO.
package bram_pkg;

  localparam int RD_LATENCY = 2;

  // Tag carried alongside a request while it is in flight toward the response FIFO.
  typedef struct packed {
    logic valid;
    logic write;
  } req_tag_t;

  // Sideband stored with each response word.
  typedef struct packed {
    logic write;
  } rsp_tag_t;

  function automatic logic [1:0] stage_count(input req_tag_t a, input req_tag_t b);
    return {1'b0, a.valid} + {1'b0, b.valid};
  endfunction

endpackage

// File: rtl/rv_fifo.sv
// Synchronous FIFO with power-of-2 depth; a push while full is taken only
// when a pop happens on the same edge, so occupancy stays unchanged.
module rv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push_valid,
  input  logic [WIDTH-1:0]         i_push_data,
  output logic                     o_pop_valid,
  input  logic                     i_pop_ready,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  assign o_pop_valid = (count != '0);
  assign pop         = o_pop_valid && i_pop_ready;
  assign push        = i_push_valid && ((count != FULL) || pop);
  assign o_pop_data  = mem[rd_ptr];
  assign o_count     = count;

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) mem[wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_pipe_rv.sv
// Single-port byte-enabled block RAM behind a ready/valid request port, with
// reads returned in order through a credit-limited response FIFO.
// Define BRAM_PIPE_WRITE_RESP_EN to also return one acknowledge beat per write.
//
// Handshake: a request transfers on a rising edge with i_req_valid && o_req_ready,
// a response transfers on a rising edge with o_rsp_valid && i_rsp_ready; valid
// never depends on ready, and o_req_ready is a function of registered state only.
module bram_pipe_rv
  import bram_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 10,
  parameter int    RESP_DEPTH = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_write,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_data,
  input  logic [DATA_WIDTH/8-1:0] i_req_be,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic                    o_rsp_write
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(RESP_DEPTH) + 1;
  localparam int OUT_W = CNT_W + 1;

`ifdef BRAM_PIPE_WRITE_RESP_EN
  localparam logic WR_RESP = 1'b1;
`else
  localparam logic WR_RESP = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q, rd_reg_q;
  req_tag_t              s1_q, s2_q;
  logic                  run_q;
  logic                  req_fire;
  logic [CNT_W-1:0]      fifo_count;
  logic [OUT_W-1:0]      outstanding;
  rsp_tag_t              push_tag, pop_tag;
  logic [DATA_WIDTH:0]   push_entry, pop_entry;
  logic                  pop_valid;

  assign req_fire    = i_req_valid && o_req_ready;
  // Every accepted beat owns a FIFO slot from acceptance until it is popped.
  assign outstanding = OUT_W'(fifo_count) + OUT_W'(stage_count(s1_q, s2_q));
  assign o_req_ready = run_q && (outstanding < OUT_W'(RESP_DEPTH));

  // Read-first RAM with an output register: two edges from accept to FIFO push.
  always_ff @(posedge i_clk) begin
    if (req_fire) begin
      if (i_req_write) begin
        for (int b = 0; b < BE_W; b++) begin
          if (i_req_be[b]) mem[i_req_addr][8*b +: 8] <= i_req_data[8*b +: 8];
        end
      end else begin
        rd_q <= mem[i_req_addr];
      end
    end
    rd_reg_q <= rd_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_q <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      run_q       <= 1'b1;
      s1_q.valid  <= req_fire && (!i_req_write || WR_RESP);
      s1_q.write  <= req_fire && i_req_write && WR_RESP;
      s2_q        <= s1_q;
    end
  end

  assign push_tag.write = s2_q.write;
  assign push_entry     = {push_tag, (s2_q.write ? {DATA_WIDTH{1'b0}} : rd_reg_q)};

  rv_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (RESP_DEPTH)
  ) u_rsp_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push_valid (s2_q.valid),
    .i_push_data  (push_entry),
    .o_pop_valid  (pop_valid),
    .i_pop_ready  (i_rsp_ready),
    .o_pop_data   (pop_entry),
    .o_count      (fifo_count)
  );

  assign pop_tag     = rsp_tag_t'(pop_entry[DATA_WIDTH]);
  assign o_rsp_valid = pop_valid;
  assign o_rsp_data  = pop_valid ? pop_entry[DATA_WIDTH-1:0] : '0;
  assign o_rsp_write = pop_valid && pop_tag.write && WR_RESP;

endmodule
